mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer/arbiter sharing the single byte-addressed RAM between the control unit's instruction-fetch path and the load/store data path. Registers each granted request, drives the RAM's MFA/MFC handshake, checks alignment, enforces a response timeout, and returns a one-cycle MFC plus read data to the winning requester. Sits in `data_path` between the MAR/MDR and the RAM.

## Interface
- `ADDR_W`, 8: RAM byte-address width.
- `TIMEOUT`, 15: maximum cycles spent in BUSY waiting for `ram_MFC` (4-bit counter).
- `CLK` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `F_MFA` in 1: fetch request; always a word read.
- `F_ADDR` in ADDR_W: fetch byte address.
- `F_DATA` out 32: fetch read data.
- `F_MFC` out 1: fetch complete, one-cycle pulse.
- `D_MFA` in 1: data request.
- `D_RW` in 1: 1 = write, 0 = read.
- `D_TYPE` in 2: access size; 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `D_ADDR` in ADDR_W: data byte address.
- `D_WDATA` in 32: write data, right-justified.
- `D_RDATA` out 32: read data, zero-extended.
- `D_MFC` out 1: data complete, one-cycle pulse.
- `ERR` out 1: qualifies the current MFC pulse; access was misaligned, reserved, or timed out.
- `ram_MFA` out 1: RAM function active.
- `ram_RW` out 1: RAM direction.
- `ram_TYPE` out 2: RAM access size.
- `ram_ADDR` out ADDR_W: RAM address.
- `ram_DIN` out 32: RAM write data.
- `ram_DOUT` in 32: RAM read data.
- `ram_MFC` in 1: RAM function complete.

## Operation
- **States.** IDLE, BUSY, RESP. `last_grant` is a 1-bit register (0 = fetch, 1 = data).
- **IDLE: arbitration.**
  - Only one of `F_MFA`/`D_MFA` high: that port wins.
  - Both high: the port not equal to `last_grant` wins.
  - On a win: latch address, type, rw, wdata and the winner id into internal registers, and update `last_grant`. Fetch latches type = 10 and rw = 0.
- **IDLE: alignment check.** The access is bad if type = 11, type = 10 with addr[1:0] ≠ 0, or type = 01 with addr[0] ≠ 0.
  - Bad access: go directly to RESP with ERR = 1. No RAM access is made.
  - Otherwise: go to BUSY.
- **BUSY.**
  - `ram_MFA` = 1. `ram_RW`/`ram_TYPE`/`ram_ADDR`/`ram_DIN` are driven from the latched registers and stay stable for the whole of BUSY.
  - Timeout counter clears on entry and increments each cycle.
  - `ram_MFC` sampled high: capture `ram_DOUT` into the winner's read-data register (reads only) and go to RESP with ERR = 0.
  - Counter reaches TIMEOUT before that: go to RESP with ERR = 1. The read-data register is unchanged.
- **RESP.**
  - `ram_MFA` = 0. The winner's MFC = 1 for exactly this cycle; ERR is valid this cycle and 0 elsewhere.
  - New requests are ignored. Next state is IDLE.
- **Request holding.** Requesters hold MFA and operands until they see their MFC, then deassert. An MFA still high in IDLE after RESP is treated as a new request.
- **Read data.** `F_DATA`/`D_RDATA` hold their last captured value until the next successful read on that port. Writes never alter them.
- **Data placement.** Byte/halfword read data is taken from `ram_DOUT[7:0]`/`[15:0]` and zero-extended.
- **Reset** (asynchronous, any state, including mid-BUSY):
  - state = IDLE, `last_grant` = 0, counter = 0.
  - All outputs 0, including `F_DATA` and `D_RDATA`.
  - An aborted access produces no MFC.

## Timing
- Request sampled at edge E0 → registered `ram_MFA` high after E0.
- `ram_MFC` sampled high at edge E1 → port MFC high from E1 to E2 → IDLE after E2. A new request is sampled at the earliest at E3.
- Minimum latency from request to MFC: 2 edges, with RAM MFC in the first BUSY cycle.
- Misaligned or reserved access: MFC high after E0+1 edge, ERR = 1.
- Timeout: MFC with ERR = 1 after E0+TIMEOUT+1 edges.
- All outputs are registered; there are no combinational input-to-output paths.
- Maximum throughput: one access per 3 cycles.

## Test plan
- **Reset.** Assert `Reset` mid-BUSY (`D_MFA`=1, RAM never responds) → all outputs 0 immediately, no `D_MFC`; after release with `F_MFA`=1, fetch is granted.
- **Word fetch.** `F_MFA`=1, `F_ADDR`=8'h04, RAM returns 32'hE3A01005 one cycle later → `ram_TYPE`=10, `ram_RW`=0, `F_MFC` one-cycle pulse, `F_DATA`=32'hE3A01005, ERR=0.
- **Tie-breaking.** `F_MFA` and `D_MFA` both held continuously from reset → grants alternate D, F, D, F; each MFC pulses once per grant.
- **Byte write.** `D_RW`=1, `D_TYPE`=00, `D_ADDR`=8'h13, `D_WDATA`=32'h000000AB → `ram_ADDR`=8'h13, `ram_DIN`=32'h000000AB, `ram_TYPE`=00; `D_RDATA` unchanged.
- **Alignment errors.** `D_TYPE`=10 with `D_ADDR`=8'h06, and `D_TYPE`=01 with `D_ADDR`=8'h03 → `ram_MFA` never rises; `D_MFC`=1 with ERR=1 one edge after sampling.
- **Timeout.** RAM holds `ram_MFC`=0, TIMEOUT=15 → `D_MFC`=1 with ERR=1 exactly 16 edges after the request is sampled, `ram_MFA` drops, and the next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM handshake bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters and RAM.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              F_MFA;
    logic [ADDR_W-1:0] F_ADDR;
    logic [31:0]       F_DATA;
    logic              F_MFC;

    logic              D_MFA;
    logic              D_RW;
    logic [1:0]        D_TYPE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [31:0]       D_WDATA;
    logic [31:0]       D_RDATA;
    logic              D_MFC;

    logic              ERR;

    logic              ram_MFA;
    logic              ram_RW;
    logic [1:0]        ram_TYPE;
    logic [ADDR_W-1:0] ram_ADDR;
    logic [31:0]       ram_DIN;
    logic [31:0]       ram_DOUT;
    logic              ram_MFC;

    modport slave (
        input  F_MFA, F_ADDR, D_MFA, D_RW, D_TYPE, D_ADDR, D_WDATA, ram_DOUT, ram_MFC,
        output F_DATA, F_MFC, D_RDATA, D_MFC, ERR,
               ram_MFA, ram_RW, ram_TYPE, ram_ADDR, ram_DIN
    );

    modport master (
        output F_MFA, F_ADDR, D_MFA, D_RW, D_TYPE, D_ADDR, D_WDATA, ram_DOUT, ram_MFC,
        input  F_DATA, F_MFC, D_RDATA, D_MFC, ERR,
               ram_MFA, ram_RW, ram_TYPE, ram_ADDR, ram_DIN
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed RAM between the fetch and load/store ports:
// alternating grant on conflict, alignment check, response timeout, one-cycle MFC.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input logic               CLK,
    input logic               Reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W     = 4;
    localparam logic [1:0]  TYPE_BYTE = 2'b00;
    localparam logic [1:0]  TYPE_HALF = 2'b01;
    localparam logic [1:0]  TYPE_WORD = 2'b10;
    localparam logic [1:0]  TYPE_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_mfa_q, ram_mfa_d;
    logic              ram_rw_q, ram_rw_d;
    logic [1:0]        ram_type_q, ram_type_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic              f_mfc_q, f_mfc_d;
    logic              d_mfc_q, d_mfc_d;
    logic              err_q, err_d;
    logic [31:0]       f_data_q, f_data_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              req;
    logic              win;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic              bad;

    // Conflict goes to the port that did not win last time (1 = data).
    assign req      = bus.F_MFA | bus.D_MFA;
    assign win      = bus.D_MFA & (~bus.F_MFA | ~last_grant_q);
    assign req_type = win ? bus.D_TYPE : TYPE_WORD;
    assign req_addr = win ? bus.D_ADDR : bus.F_ADDR;
    assign bad      = (req_type == TYPE_RSVD)
                   || (req_type == TYPE_WORD && req_addr[1:0] != 2'b00)
                   || (req_type == TYPE_HALF && req_addr[0]);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        ram_mfa_d    = ram_mfa_q;
        ram_rw_d     = ram_rw_q;
        ram_type_d   = ram_type_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        f_mfc_d      = 1'b0;
        d_mfc_d      = 1'b0;
        err_d        = 1'b0;
        f_data_d     = f_data_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    id_d         = win;
                    last_grant_d = win;
                    ram_rw_d     = win & bus.D_RW;
                    ram_type_d   = req_type;
                    ram_addr_d   = req_addr;
                    ram_din_d    = bus.D_WDATA;
                    cnt_d        = '0;
                    if (bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        f_mfc_d = ~win;
                        d_mfc_d = win;
                    end else begin
                        state_d   = BUSY;
                        ram_mfa_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.ram_MFC) begin
                    state_d   = RESP;
                    ram_mfa_d = 1'b0;
                    f_mfc_d   = ~id_q;
                    d_mfc_d   = id_q;
                    if (!ram_rw_q) begin
                        if (id_q) begin
                            case (ram_type_q)
                                TYPE_BYTE: d_rdata_d = {24'b0, bus.ram_DOUT[7:0]};
                                TYPE_HALF: d_rdata_d = {16'b0, bus.ram_DOUT[15:0]};
                                default:   d_rdata_d = bus.ram_DOUT;
                            endcase
                        end else begin
                            f_data_d = bus.ram_DOUT;
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Counter has now covered TIMEOUT BUSY cycles without a response.
                    state_d   = RESP;
                    ram_mfa_d = 1'b0;
                    err_d     = 1'b1;
                    f_mfc_d   = ~id_q;
                    d_mfc_d   = id_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                ram_mfa_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            ram_mfa_q    <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_type_q   <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            f_mfc_q      <= 1'b0;
            d_mfc_q      <= 1'b0;
            err_q        <= 1'b0;
            f_data_q     <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            ram_mfa_q    <= ram_mfa_d;
            ram_rw_q     <= ram_rw_d;
            ram_type_q   <= ram_type_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            f_mfc_q      <= f_mfc_d;
            d_mfc_q      <= d_mfc_d;
            err_q        <= err_d;
            f_data_q     <= f_data_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.ram_MFA  = ram_mfa_q;
    assign bus.ram_RW   = ram_rw_q;
    assign bus.ram_TYPE = ram_type_q;
    assign bus.ram_ADDR = ram_addr_q;
    assign bus.ram_DIN  = ram_din_q;
    assign bus.F_MFC    = f_mfc_q;
    assign bus.D_MFC    = d_mfc_q;
    assign bus.ERR      = err_q;
    assign bus.F_DATA   = f_data_q;
    assign bus.D_RDATA  = d_rdata_q;
endmodule
